main_ctrl_fsm: RTL and testbench
================================

Name: main_ctrl_fsm

Overview:
- Multicycle main control unit for the MIPS-subset datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath enables and muxes, and produces the 4-bit ALUOp consumed by the ALU control decoder.
- Opcode and funct come from the instruction register, which is stable from the cycle after a FETCH completes until the next FETCH.

Parameters:
- HALT_ON_ILLEGAL, 0: 1 = an illegal opcode parks the FSM in HALT until reset; 0 = return to FETCH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory handshake; access completes in a cycle where it is 1.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load gated by the branch condition (datapath evaluates).
- branch_ne  out  1  1 = the branch condition is !zero; 0 = zero.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_write  out  1  register file write.
- reg_dst  out  2  write register: 00 = rt, 01 = rd, 10 = $31.
- mem_to_reg  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = extended imm, 11 = imm<<2.
- imm_zero_ext  out  1  1 = zero-extend imm16.
- alu_op  out  4  ALUOp: 0000 add, 0001 branch, 0010 rtype, 0011 and, 0100 or, 0101 xor, 0110 lui, 0111 slt, 1000 sltu.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (jr).
- illegal  out  1  one-cycle pulse on an undefined opcode.
- state  out  4  current state, for debug.

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, JR=12, HALT=15.
- Outputs are Moore functions of state, except the mem_ready-gated enables noted below. Any output not listed for a state is 0.
- While rst=1: every output is 0 and state is 0. The next edge with rst=1 loads FETCH, which aborts any in-flight instruction. The first FETCH cycle is the first cycle with rst=0.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=0000, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=0000.
  - Next state by opcode:
    - 0x00 with funct 0x08 -> JR; 0x00 with any other funct -> REXEC.
    - 0x23 or 0x2B -> MEMADR.
    - 0x04 or 0x05 -> BRANCH.
    - 0x02 or 0x03 -> JUMP.
    - 0x08, 0x0A, 0x0B, 0x0C, 0x0D, 0x0E, 0x0F -> IEXEC.
    - Anything else: illegal=1 for this cycle, then FETCH, or HALT if HALT_ON_ILLEGAL=1.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=0000. Next: MEMRD if opcode is 0x23, else MEMWR.
- MEMRD: mem_read=1, iord=1. Waits for mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01. Next: FETCH.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready=1, then FETCH.
- REXEC: alu_src_a=1, alu_src_b=00, alu_op=0010. Next: RWB.
- RWB: reg_write=1, reg_dst=01, mem_to_reg=00. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=0001, pc_write_cond=1, pc_source=01, branch_ne=(opcode==0x05). Next: FETCH.
- IEXEC:
  - alu_src_a=1, alu_src_b=10.
  - alu_op by opcode: 0x08 -> 0000, 0x0A -> 0111, 0x0B -> 1000, 0x0C -> 0011, 0x0D -> 0100, 0x0E -> 0101, 0x0F -> 0110.
  - imm_zero_ext=1 for 0x0C/0x0D/0x0E, else 0.
  - Next: IWB.
- IWB: reg_write=1, reg_dst=00, mem_to_reg=00. Next: FETCH.
- JUMP:
  - pc_write=1, pc_source=10.
  - If opcode is 0x03 (jal), also reg_write=1, reg_dst=10, mem_to_reg=10.
  - Next: FETCH.
- JR: pc_write=1, pc_source=11. Next: FETCH.
- HALT: all outputs 0; left only by reset.
- Cycle counts with mem_ready tied to 1:
  - lw 5; sw 4; R-type 4; I-type ALU 4; beq/bne 3; j/jal/jr 3.
  - Each extra mem_ready=0 cycle adds one cycle.
- Invariants:
  - mem_read and mem_write are never both 1.
  - pc_write and pc_write_cond are never both 1.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.

Test Plan:
- Reset: rst=1 for 2 cycles with mem_ready=1 -> all outputs 0 during reset; the first cycle after rst drops shows state=0, mem_read=1, pc_write=1, ir_write=1.
- lw (opcode 0x23), mem_ready=1 -> states 0,1,2,3,4,0; MEMWB shows reg_write=1, mem_to_reg=01, reg_dst=00.
- Memory stall: sw (opcode 0x2B) with mem_ready=0 for 3 cycles in MEMWR -> mem_write=1 held 4 cycles, pc_write never asserted there, then FETCH.
- R-type add (0x00/0x20) -> REXEC alu_op=0010; RWB reg_dst=01. jr (0x00/0x08) -> JR state with pc_source=11.
- ori (0x0D) -> IEXEC alu_op=0100, imm_zero_ext=1. slti (0x0A) -> alu_op=0111, imm_zero_ext=0. bne (0x05) -> BRANCH alu_op=0001, branch_ne=1, pc_write_cond=1.
- Illegal opcode 0x3F -> illegal=1 for exactly one cycle in DECODE; with HALT_ON_ILLEGAL=0 next state is 0; with HALT_ON_ILLEGAL=1 state stays 15 until rst.

Source files
------------

// File: rtl/main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : main_ctrl_fsm
//  Description : Multicycle main control unit for the MIPS-subset datapath.
//                Steps each instruction through fetch, decode, execute,
//                memory and writeback, and drives every datapath enable,
//                mux select and the 4-bit ALUOp for the ALU control decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_ctrl_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zero_ext,
    output logic [3:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal,
    output logic [3:0] state
);

    // State codes are visible on the debug port, so they are fixed values.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JR     = 4'd12,
        S_HALT   = 4'd15
    } state_t;

    // Opcodes and functs recognised by the decoder.
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_JR    = 6'h08;

    // ALUOp encodings understood by the ALU control decoder.
    localparam logic [3:0] c_ALU_ADD    = 4'b0000;
    localparam logic [3:0] c_ALU_BRANCH = 4'b0001;
    localparam logic [3:0] c_ALU_RTYPE  = 4'b0010;
    localparam logic [3:0] c_ALU_AND    = 4'b0011;
    localparam logic [3:0] c_ALU_OR     = 4'b0100;
    localparam logic [3:0] c_ALU_XOR    = 4'b0101;
    localparam logic [3:0] c_ALU_LUI    = 4'b0110;
    localparam logic [3:0] c_ALU_SLT    = 4'b0111;
    localparam logic [3:0] c_ALU_SLTU   = 4'b1000;

    state_t     r_state;
    state_t     w_next;
    state_t     w_dec_next;
    logic       w_dec_illegal;
    logic [3:0] w_imm_alu_op;
    logic       w_imm_zext;

    // Dispatch from DECODE: picks the execute state for the opcode in IR.
    always_comb begin
        w_dec_next    = S_FETCH;
        w_dec_illegal = 1'b0;
        case (opcode)
            c_OP_RTYPE: w_dec_next = (funct == c_FN_JR) ? S_JR : S_REXEC;
            c_OP_LW,
            c_OP_SW:    w_dec_next = S_MEMADR;
            c_OP_BEQ,
            c_OP_BNE:   w_dec_next = S_BRANCH;
            c_OP_J,
            c_OP_JAL:   w_dec_next = S_JUMP;
            c_OP_ADDI,
            c_OP_SLTI,
            c_OP_SLTIU,
            c_OP_ANDI,
            c_OP_ORI,
            c_OP_XORI,
            c_OP_LUI:   w_dec_next = S_IEXEC;
            default: begin
                w_dec_illegal = 1'b1;
                w_dec_next    = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
            end
        endcase
    end

    // Immediate-ALU flavour: ALUOp and whether imm16 is zero-extended.
    always_comb begin
        w_imm_alu_op = c_ALU_ADD;
        w_imm_zext   = 1'b0;
        case (opcode)
            c_OP_SLTI:  w_imm_alu_op = c_ALU_SLT;
            c_OP_SLTIU: w_imm_alu_op = c_ALU_SLTU;
            c_OP_ANDI: begin
                w_imm_alu_op = c_ALU_AND;
                w_imm_zext   = 1'b1;
            end
            c_OP_ORI: begin
                w_imm_alu_op = c_ALU_OR;
                w_imm_zext   = 1'b1;
            end
            c_OP_XORI: begin
                w_imm_alu_op = c_ALU_XOR;
                w_imm_zext   = 1'b1;
            end
            c_OP_LUI:   w_imm_alu_op = c_ALU_LUI;
            default:    w_imm_alu_op = c_ALU_ADD;
        endcase
    end

    // Next-state logic; mem_ready only matters in the three memory-access states.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_dec_next;
            S_MEMADR: w_next = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_REXEC:  w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_IEXEC:  w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
            S_JR:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // State register; reset aborts any in-flight instruction back to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Output decode. Outputs are forced low while rst is high, because the
    // register already holds FETCH (code 0) during a multi-cycle reset and
    // the first FETCH cycle must be the first cycle with rst low.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        imm_zero_ext  = 1'b0;
        alu_op        = c_ALU_ADD;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        state         = 4'd0;
        if (!rst) begin
            state = r_state;
            case (r_state)
                S_FETCH: begin
                    // PC+4 is computed by the ALU while memory returns the word.
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    // Speculative branch target PC + (imm << 2) into ALUOut.
                    alu_src_b = 2'b11;
                    illegal   = w_dec_illegal;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_REXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = c_ALU_RTYPE;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b01;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = c_ALU_BRANCH;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    branch_ne     = (opcode == c_OP_BNE);
                end
                S_IEXEC: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = 2'b10;
                    alu_op       = w_imm_alu_op;
                    imm_zero_ext = w_imm_zext;
                end
                S_IWB: begin
                    reg_write = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    if (opcode == c_OP_JAL) begin
                        // jal links the return address into $31.
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                end
                S_JR: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b11;
                end
                default: begin
                    // HALT and unused codes drive everything inactive.
                end
            endcase
        end
    end

    // Structural invariants of the datapath control.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_read && mem_write));
            assert (!(pc_write && pc_write_cond));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_ctrl_fsm
//  Description : Self-checking bench for main_ctrl_fsm: cycle-count table,
//                hand-written corner sequences and randomized instruction
//                streams compared against an instruction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_main_ctrl_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zero_ext;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
        logic [3:0] state;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         cycles;
        int         st2;
        int         aop2;
    } vec_t;

    typedef int iq_t[$];

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;

    logic       a_pc_write, a_pc_write_cond, a_branch_ne, a_iord, a_mem_read, a_mem_write;
    logic       a_ir_write, a_reg_write, a_alu_src_a, a_imm_zero_ext, a_illegal;
    logic [1:0] a_reg_dst, a_mem_to_reg, a_alu_src_b, a_pc_source;
    logic [3:0] a_alu_op, a_state;
    logic       b_pc_write, b_pc_write_cond, b_branch_ne, b_iord, b_mem_read, b_mem_write;
    logic       b_ir_write, b_reg_write, b_alu_src_a, b_imm_zero_ext, b_illegal;
    logic [1:0] b_reg_dst, b_mem_to_reg, b_alu_src_b, b_pc_source;
    logic [3:0] b_alu_op, b_state;

    outs_t got_now, got_h_now, got, got_h;
    int    checks   = 0;
    int    failures = 0;

    main_ctrl_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond), .branch_ne(a_branch_ne),
        .iord(a_iord), .mem_read(a_mem_read), .mem_write(a_mem_write), .ir_write(a_ir_write),
        .reg_write(a_reg_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .imm_zero_ext(a_imm_zero_ext),
        .alu_op(a_alu_op), .pc_source(a_pc_source), .illegal(a_illegal), .state(a_state)
    );

    main_ctrl_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .branch_ne(b_branch_ne),
        .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
        .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .imm_zero_ext(b_imm_zero_ext),
        .alu_op(b_alu_op), .pc_source(b_pc_source), .illegal(b_illegal), .state(b_state)
    );

    assign got_now = {a_pc_write, a_pc_write_cond, a_branch_ne, a_iord, a_mem_read, a_mem_write,
                      a_ir_write, a_reg_write, a_reg_dst, a_mem_to_reg, a_alu_src_a, a_alu_src_b,
                      a_imm_zero_ext, a_alu_op, a_pc_source, a_illegal, a_state};
    assign got_h_now = {b_pc_write, b_pc_write_cond, b_branch_ne, b_iord, b_mem_read, b_mem_write,
                        b_ir_write, b_reg_write, b_reg_dst, b_mem_to_reg, b_alu_src_a, b_alu_src_b,
                        b_imm_zero_ext, b_alu_op, b_pc_source, b_illegal, b_state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit is_legal(input logic [5:0] op);
        logic [5:0] legal [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
                                    6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        foreach (legal[i]) if (legal[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] imm_aluop(input logic [5:0] op);
        case (op)
            6'h0A:   return 4'b0111;
            6'h0B:   return 4'b1000;
            6'h0C:   return 4'b0011;
            6'h0D:   return 4'b0100;
            6'h0E:   return 4'b0101;
            6'h0F:   return 4'b0110;
            default: return 4'b0000;
        endcase
    endfunction

    // Expected outputs for a given spec state code; st < 0 means "in reset".
    function automatic outs_t exp_out(input int st, input logic [5:0] op, input logic mr);
        outs_t e = '0;
        if (st < 0) return e;
        e.state = st[3:0];
        case (st)
            0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
            1:  begin e.alu_src_b = 2'b11; e.illegal = !is_legal(op); end
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            3:  begin e.mem_read = 1; e.iord = 1; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 2'b01; end
            5:  begin e.mem_write = 1; e.iord = 1; end
            6:  begin e.alu_src_a = 1; e.alu_op = 4'b0010; end
            7:  begin e.reg_write = 1; e.reg_dst = 2'b01; end
            8:  begin e.alu_src_a = 1; e.alu_op = 4'b0001; e.pc_write_cond = 1;
                      e.pc_source = 2'b01; e.branch_ne = (op == 6'h05); end
            9:  begin e.pc_write = 1; e.pc_source = 2'b10;
                      if (op == 6'h03) begin e.reg_write = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
                end
            10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = imm_aluop(op);
                      e.imm_zero_ext = (op == 6'h0C || op == 6'h0D || op == 6'h0E); end
            11: begin e.reg_write = 1; end
            12: begin e.pc_write = 1; e.pc_source = 2'b11; end
            default: ;
        endcase
        return e;
    endfunction

    // States visited after FETCH for one instruction, by instruction class.
    function automatic iq_t post_fetch_path(input logic [5:0] op, input logic [5:0] fn);
        iq_t q;
        q.push_back(1);
        if (op == 6'h00) begin
            if (fn == 6'h08) q.push_back(12);
            else begin q.push_back(6); q.push_back(7); end
        end else if (op == 6'h23) begin
            q.push_back(2); q.push_back(3); q.push_back(4);
        end else if (op == 6'h2B) begin
            q.push_back(2); q.push_back(5);
        end else if (op == 6'h04 || op == 6'h05) begin
            q.push_back(8);
        end else if (op == 6'h02 || op == 6'h03) begin
            q.push_back(9);
        end else if (is_legal(op)) begin
            q.push_back(10); q.push_back(11);
        end
        return q;
    endfunction

    // ---------------- helpers ----------------
    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic mr);
        rst = r; opcode = op; funct = fn; mem_ready = mr;
        @(negedge clk);
        got   = got_now;
        got_h = got_h_now;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (state got=%0d exp=%0d)",
                     name, act, exp, act.state, exp.state);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one instruction from FETCH with the given stall counts, checking every cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fs, input int ms);
        iq_t  path;
        logic mr;
        for (int i = 0; i < fs; i++) begin
            step(1'b0, 6'($urandom), 6'($urandom), 1'b0);
            chk("fetch_stall", got, exp_out(0, op, 1'b0));
        end
        step(1'b0, 6'($urandom), 6'($urandom), 1'b1);
        chk("fetch", got, exp_out(0, op, 1'b1));
        path = post_fetch_path(op, fn);
        foreach (path[k]) begin
            if (path[k] == 3 || path[k] == 5) begin
                for (int i = 0; i < ms; i++) begin
                    step(1'b0, op, fn, 1'b0);
                    chk("mem_stall", got, exp_out(path[k], op, 1'b0));
                end
                step(1'b0, op, fn, 1'b1);
                chk("mem_done", got, exp_out(path[k], op, 1'b1));
            end else begin
                mr = 1'($urandom);
                step(1'b0, op, fn, mr);
                chk("exec", got, exp_out(path[k], op, mr));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    initial begin
        vec_t tbl [16];
        int   n, st2, aop2;
        bit   seen;
        logic [5:0] rop, rfn;

        tbl[0]  = '{6'h23, 6'h00, 5, 2,  0};
        tbl[1]  = '{6'h2B, 6'h00, 4, 2,  0};
        tbl[2]  = '{6'h00, 6'h20, 4, 6,  2};
        tbl[3]  = '{6'h00, 6'h08, 3, 12, 0};
        tbl[4]  = '{6'h04, 6'h00, 3, 8,  1};
        tbl[5]  = '{6'h05, 6'h00, 3, 8,  1};
        tbl[6]  = '{6'h02, 6'h00, 3, 9,  0};
        tbl[7]  = '{6'h03, 6'h00, 3, 9,  0};
        tbl[8]  = '{6'h08, 6'h00, 4, 10, 0};
        tbl[9]  = '{6'h0A, 6'h00, 4, 10, 7};
        tbl[10] = '{6'h0B, 6'h00, 4, 10, 8};
        tbl[11] = '{6'h0C, 6'h00, 4, 10, 3};
        tbl[12] = '{6'h0D, 6'h00, 4, 10, 4};
        tbl[13] = '{6'h0E, 6'h00, 4, 10, 5};
        tbl[14] = '{6'h0F, 6'h00, 4, 10, 6};
        tbl[15] = '{6'h3F, 6'h00, 2, 0,  0};

        rst = 1'b1; opcode = 6'h00; funct = 6'h00; mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset: two cycles of rst with mem_ready high, then the first FETCH.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 6'h00, 6'h00, 1'b1);
            chk("reset_outs", got, exp_out(-1, 6'h00, 1'b1));
            chk("reset_outs_h", got_h, exp_out(-1, 6'h00, 1'b1));
        end
        run_instr(6'h23, 6'h00, 0, 0);              // lw, no stalls
        run_instr(6'h2B, 6'h00, 0, 3);              // sw with 3 stall cycles in MEMWR
        run_instr(6'h00, 6'h20, 1, 0);              // add
        run_instr(6'h00, 6'h08, 0, 0);              // jr
        run_instr(6'h0D, 6'h00, 0, 0);              // ori
        run_instr(6'h0A, 6'h00, 0, 0);              // slti
        run_instr(6'h05, 6'h00, 0, 0);              // bne
        run_instr(6'h03, 6'h00, 0, 0);              // jal
        run_instr(6'h3F, 6'h00, 0, 0);              // illegal, returns to FETCH
        step(1'b0, 6'h00, 6'h00, 1'b0);
        chk("after_illegal", got, exp_out(0, 6'h00, 1'b0));

        // Cycle-count table with mem_ready tied high.
        foreach (tbl[i]) begin
            step(1'b1, tbl[i].op, tbl[i].fn, 1'b1);
            chk("tbl_reset", got, exp_out(-1, 6'h00, 1'b1));
            step(1'b0, tbl[i].op, tbl[i].fn, 1'b1);
            chk("tbl_fetch", got, exp_out(0, 6'h00, 1'b1));
            n = 1; seen = 1'b0; st2 = -1; aop2 = -1;
            for (int k = 0; k < 12 && !seen; k++) begin
                step(1'b0, tbl[i].op, tbl[i].fn, 1'b1);
                if (k == 1) begin
                    st2  = int'(got.state);
                    aop2 = int'(got.alu_op);
                end
                if (got.state == 4'd0) seen = 1'b1;
                else n++;
            end
            if (!seen) begin
                chk_int("tbl_timeout", 0, 1);
            end else begin
                chk_int("tbl_cycles", n, tbl[i].cycles);
                chk_int("tbl_state2", st2, tbl[i].st2);
                chk_int("tbl_aluop2", aop2, tbl[i].aop2);
            end
        end

        // Illegal opcode with both HALT_ON_ILLEGAL settings.
        step(1'b1, 6'h3F, 6'h00, 1'b1);
        chk("halt_rst", got_h, exp_out(-1, 6'h00, 1'b1));
        step(1'b0, 6'h3F, 6'h00, 1'b1);
        chk("halt_fetch", got_h, exp_out(0, 6'h3F, 1'b1));
        step(1'b0, 6'h3F, 6'h00, 1'b1);
        chk("ill_decode", got, exp_out(1, 6'h3F, 1'b1));
        chk("ill_decode_h", got_h, exp_out(1, 6'h3F, 1'b1));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 6'($urandom), 6'h00, 1'b0);
            chk("ill_back_to_fetch", got, exp_out(0, 6'h00, 1'b0));
            chk("halt_hold", got_h, exp_out(15, 6'h00, 1'b0));
        end
        step(1'b1, 6'h00, 6'h00, 1'b1);
        chk("halt_reset", got_h, exp_out(-1, 6'h00, 1'b1));
        step(1'b0, 6'h00, 6'h00, 1'b0);
        chk("halt_exit", got_h, exp_out(0, 6'h00, 1'b0));

        // Reset in the middle of a stalled lw aborts it.
        step(1'b1, 6'h23, 6'h00, 1'b1);
        run_instr(6'h2B, 6'h00, 0, 0);
        step(1'b0, 6'h00, 6'h00, 1'b1);
        step(1'b0, 6'h23, 6'h00, 1'b1);
        step(1'b0, 6'h23, 6'h00, 1'b1);
        step(1'b0, 6'h23, 6'h00, 1'b0);
        chk("abort_memrd", got, exp_out(3, 6'h23, 1'b0));
        step(1'b1, 6'h23, 6'h00, 1'b1);
        chk("abort_reset", got, exp_out(-1, 6'h23, 1'b1));
        step(1'b0, 6'h23, 6'h00, 1'b0);
        chk("abort_fetch", got, exp_out(0, 6'h23, 1'b0));
        step(1'b1, 6'h00, 6'h00, 1'b1);

        // Randomized instruction stream with random stalls.
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 99) < 15) begin
                rop = 6'($urandom);
            end else begin
                case ($urandom_range(0, 13))
                    0:  rop = 6'h00;  1:  rop = 6'h02;  2:  rop = 6'h03;  3:  rop = 6'h04;
                    4:  rop = 6'h05;  5:  rop = 6'h08;  6:  rop = 6'h0A;  7:  rop = 6'h0B;
                    8:  rop = 6'h0C;  9:  rop = 6'h0D;  10: rop = 6'h0E;  11: rop = 6'h0F;
                    12: rop = 6'h23;  default: rop = 6'h2B;
                endcase
            end
            rfn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            run_instr(rop, rfn, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        step(1'b0, 6'h00, 6'h00, 1'b0);
        chk("final_fetch", got, exp_out(0, 6'h00, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
